// File: rtl/fpalu_pipe.sv
// fpalu_pipe: four-stage pipelined float add/sub/mul/pass with valid/ready stall.
// Results are normalised (man msb set) or exact zero; exponent saturates or flushes.
module fpalu_pipe #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 22,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             a_sgn,
    input  logic             b_sgn,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [MAN_W-1:0] a_man,
    input  logic [MAN_W-1:0] b_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y_sgn,
    output logic [EXP_W-1:0] y_exp,
    output logic [MAN_W-1:0] y_man,
    output logic [TAG_W-1:0] y_tag,
    output logic             y_ovf,
    output logic             y_unf
);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int XW   = EXP_W + 2;
    localparam int LZ_W = $clog2(MAN_W + 1);
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    logic                 w_en;
    logic                 r1_v, r1_mul, r1_sgn_l, r1_sgn_r;
    logic [MAN_W-1:0]     r1_man_l, r1_man_r;
    logic signed [XW-1:0] r1_exp;
    logic [TAG_W-1:0]     r1_tag;
    logic                 r2_v, r2_sgn;
    logic [MAN_W-1:0]     r2_man;
    logic signed [XW-1:0] r2_exp;
    logic [TAG_W-1:0]     r2_tag;
    logic                 r3_v, r3_sgn;
    logic [MAN_W-1:0]     r3_man;
    logic signed [XW-1:0] r3_exp;
    logic [TAG_W-1:0]     r3_tag;
    logic [LZ_W-1:0]      r3_lzc;

    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    // S1: pick the larger-exponent operand L and align the other one (R) to it.
    logic                 w_b_sgn, w_a_ge;
    logic [EXP_W-1:0]     w_diff;
    logic                 w1_sgn_l, w1_sgn_r;
    logic [MAN_W-1:0]     w1_man_l, w1_man_r;
    logic signed [XW-1:0] w1_exp;

    always_comb begin
        w_b_sgn  = b_sgn ^ (in_op == OP_SUB);
        w_a_ge   = (a_exp >= b_exp);
        w_diff   = w_a_ge ? (a_exp - b_exp) : (b_exp - a_exp);
        w1_sgn_l = a_sgn;
        w1_sgn_r = a_sgn;
        w1_man_l = a_man;
        w1_man_r = '0;
        w1_exp   = {2'b00, a_exp};
        if (in_op == OP_MUL) begin
            w1_sgn_l = a_sgn ^ b_sgn;
            w1_man_r = b_man;
            w1_exp   = {2'b00, a_exp} + {2'b00, b_exp} - XW'(BIAS);
        end else if (in_op != OP_PASS && b_man != '0) begin
            // a zero mantissa is exact zero, so its exponent must not win alignment
            if (a_man == '0) begin
                w1_sgn_l = w_b_sgn;
                w1_sgn_r = w_b_sgn;
                w1_man_l = b_man;
                w1_exp   = {2'b00, b_exp};
            end else if (w_a_ge) begin
                w1_sgn_r = w_b_sgn;
                w1_man_r = b_man >> w_diff;
            end else begin
                w1_sgn_l = w_b_sgn;
                w1_man_l = b_man;
                w1_exp   = {2'b00, b_exp};
                w1_sgn_r = a_sgn;
                w1_man_r = a_man >> w_diff;
            end
        end
    end

    // S2: magnitude add/subtract or truncating multiply.
    logic [2*MAN_W-1:0]   w_prod;
    logic [MAN_W:0]       w_sum;
    logic                 w2_sgn;
    logic [MAN_W-1:0]     w2_man;
    logic signed [XW-1:0] w2_exp;

    always_comb begin
        w_prod = {{MAN_W{1'b0}}, r1_man_l} * {{MAN_W{1'b0}}, r1_man_r};
        w_sum  = {1'b0, r1_man_l} + {1'b0, r1_man_r};
        w2_sgn = r1_sgn_l;
        w2_man = w_sum[MAN_W-1:0];
        w2_exp = r1_exp;
        if (r1_mul) begin
            w2_man = w_prod[2*MAN_W-1:MAN_W];
        end else if (r1_sgn_l == r1_sgn_r) begin
            if (w_sum[MAN_W]) begin
                w2_man = w_sum[MAN_W:1];
                w2_exp = r1_exp + XW'(1);
            end
        end else if (r1_man_l >= r1_man_r) begin
            w2_man = r1_man_l - r1_man_r;
        end else begin
            w2_man = r1_man_r - r1_man_l;
            w2_sgn = r1_sgn_r;
        end
    end

    // S3: leading-zero count; the highest set bit is the last one to assign.
    logic [LZ_W-1:0] w_lzc;

    always_comb begin
        w_lzc = LZ_W'(MAN_W);
        for (int i = 0; i < MAN_W; i++) begin
            if (r2_man[i]) w_lzc = LZ_W'(MAN_W - 1 - i);
        end
    end

    logic signed [XW-1:0] w_exp_adj;
    logic [MAN_W-1:0]     w_man_norm;

    assign w_exp_adj  = r3_exp - XW'(r3_lzc);
    assign w_man_norm = r3_man << r3_lzc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_v <= 1'b0; r1_mul <= 1'b0; r1_sgn_l <= 1'b0; r1_sgn_r <= 1'b0;
            r1_man_l <= '0; r1_man_r <= '0; r1_exp <= '0; r1_tag <= '0;
            r2_v <= 1'b0; r2_sgn <= 1'b0; r2_man <= '0; r2_exp <= '0; r2_tag <= '0;
            r3_v <= 1'b0; r3_sgn <= 1'b0; r3_man <= '0; r3_exp <= '0; r3_tag <= '0;
            r3_lzc <= '0;
            out_valid <= 1'b0; y_sgn <= 1'b0; y_exp <= '0; y_man <= '0;
            y_tag <= '0; y_ovf <= 1'b0; y_unf <= 1'b0;
        end else if (w_en) begin
            r1_v <= in_valid;
            if (in_valid) begin
                r1_mul   <= (in_op == OP_MUL);
                r1_sgn_l <= w1_sgn_l;
                r1_sgn_r <= w1_sgn_r;
                r1_man_l <= w1_man_l;
                r1_man_r <= w1_man_r;
                r1_exp   <= w1_exp;
                r1_tag   <= in_tag;
            end
            r2_v <= r1_v;
            if (r1_v) begin
                r2_sgn <= w2_sgn;
                r2_man <= w2_man;
                r2_exp <= w2_exp;
                r2_tag <= r1_tag;
            end
            r3_v <= r2_v;
            if (r2_v) begin
                r3_sgn <= r2_sgn;
                r3_man <= r2_man;
                r3_exp <= r2_exp;
                r3_tag <= r2_tag;
                r3_lzc <= w_lzc;
            end
            out_valid <= r3_v;
            if (r3_v) begin
                y_tag <= r3_tag;
                y_ovf <= 1'b0;
                y_unf <= 1'b0;
                if (r3_man == '0) begin
                    y_sgn <= 1'b0;
                    y_exp <= '0;
                    y_man <= '0;
                end else if (w_exp_adj[XW-1]) begin
                    y_sgn <= 1'b0;
                    y_exp <= '0;
                    y_man <= '0;
                    y_unf <= 1'b1;
                end else if (w_exp_adj > EXP_MAX) begin
                    y_sgn <= r3_sgn;
                    y_exp <= '1;
                    y_man <= '1;
                    y_ovf <= 1'b1;
                end else begin
                    y_sgn <= r3_sgn;
                    y_exp <= w_exp_adj[EXP_W-1:0];
                    y_man <= w_man_norm;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpalu_pipe.sv
// tb_fpalu_pipe: directed and randomized checks of fpalu_pipe against an arithmetic model.
module tb_fpalu_pipe;
    localparam int EXP_W = 6;
    localparam int MAN_W = 22;
    localparam int TAG_W = 4;
    localparam int BIAS  = 31;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             a_sgn = 1'b0, b_sgn = 1'b0;
    logic [EXP_W-1:0] a_exp = '0, b_exp = '0;
    logic [MAN_W-1:0] a_man = '0, b_man = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             y_sgn;
    logic [EXP_W-1:0] y_exp;
    logic [MAN_W-1:0] y_man;
    logic [TAG_W-1:0] y_tag;
    logic             y_ovf, y_unf;

    always #5 clk = ~clk;

    fpalu_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_tag(in_tag), .a_sgn(a_sgn), .b_sgn(b_sgn),
        .a_exp(a_exp), .b_exp(b_exp), .a_man(a_man), .b_man(b_man),
        .out_valid(out_valid), .out_ready(out_ready), .y_sgn(y_sgn),
        .y_exp(y_exp), .y_man(y_man), .y_tag(y_tag), .y_ovf(y_ovf), .y_unf(y_unf)
    );

    typedef struct packed {
        logic             sgn;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             ovf;
        logic             unf;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Value-level reference: integer mantissa arithmetic, then normalise by doubling.
    function automatic res_t model(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                                   input logic as, input logic [EXP_W-1:0] ae, input logic [MAN_W-1:0] am,
                                   input logic bs, input logic [EXP_W-1:0] be, input logic [MAN_W-1:0] bm);
        res_t   r;
        longint lm, rm, m;
        int     le, re, e, d;
        logic   ls, rs, s, bse;
        r = '0;
        r.tag = tag;
        bse = bs ^ (op == 2'b01);
        s = as;
        m = longint'(am);
        e = int'(ae);
        if (op == 2'b10) begin
            s = as ^ bs;
            m = (longint'(am) * longint'(bm)) >> MAN_W;
            e = int'(ae) + int'(be) - BIAS;
        end else if (op != 2'b11 && bm != 0) begin
            if (am == 0) begin
                s = bse; m = longint'(bm); e = int'(be);
            end else begin
                if (ae >= be) begin
                    ls = as;  lm = longint'(am); le = int'(ae);
                    rs = bse; rm = longint'(bm); re = int'(be);
                end else begin
                    ls = bse; lm = longint'(bm); le = int'(be);
                    rs = as;  rm = longint'(am); re = int'(ae);
                end
                d = le - re;
                rm = (d >= MAN_W) ? 0 : (rm >> d);
                e = le;
                if (ls == rs) begin
                    s = ls;
                    m = lm + rm;
                    if (m >= (longint'(1) << MAN_W)) begin
                        m = m >> 1;
                        e = e + 1;
                    end
                end else if (lm >= rm) begin
                    s = ls; m = lm - rm;
                end else begin
                    s = rs; m = rm - lm;
                end
            end
        end
        if (m == 0) return r;
        while (m < (longint'(1) << (MAN_W - 1))) begin
            m = m << 1;
            e = e - 1;
        end
        if (e > (1 << EXP_W) - 1) begin
            r.sgn = s; r.exp = '1; r.man = '1; r.ovf = 1'b1;
        end else if (e < 0) begin
            r.unf = 1'b1;
        end else begin
            r.sgn = s; r.exp = e[EXP_W-1:0]; r.man = m[MAN_W-1:0];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total = n_total + 1;
        assert (got === want) n_pass = n_pass + 1;
        else $error("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    // Scoreboard: every input transfer queues a model result, every output transfer pops one.
    res_t m_exp, m_obs;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_total = n_total + 1;
                m_obs = {y_sgn, y_exp, y_man, y_ovf, y_unf, y_tag};
                if (sb.size() == 0) begin
                    $error("FAIL unexpected_output: got %h want none", m_obs);
                end else begin
                    m_exp = sb.pop_front();
                    assert (m_obs === m_exp) n_pass = n_pass + 1;
                    else $error("FAIL result tag=%0d: got %h want %h", m_exp.tag, m_obs, m_exp);
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_op, in_tag, a_sgn, a_exp, a_man, b_sgn, b_exp, b_man));
        end
    end

    task automatic run_one(input string name, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                           input logic as, input logic [EXP_W-1:0] ae, input logic [MAN_W-1:0] am,
                           input logic bs, input logic [EXP_W-1:0] be, input logic [MAN_W-1:0] bm,
                           input logic ws, input logic [EXP_W-1:0] we, input logic [MAN_W-1:0] wm,
                           input logic wo, input logic wu);
        int n;
        in_op = op; in_tag = tag;
        a_sgn = as; a_exp = ae; a_man = am;
        b_sgn = bs; b_exp = be; b_man = bm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        check({name, "_latency"}, 64'(n), 64'd4);
        check(name, 64'({y_sgn, y_exp, y_man, y_ovf, y_unf}), 64'({ws, we, wm, wo, wu}));
        @(posedge clk); #1;
    endtask

    function automatic logic [MAN_W-1:0] rand_man();
        case ($urandom_range(0, 7))
            0:       return '0;
            1, 2:    return MAN_W'($urandom) >> $urandom_range(0, MAN_W - 1);
            default: return MAN_W'($urandom);
        endcase
    endfunction

    task automatic rand_op();
        in_op  = 2'($urandom);
        in_tag = TAG_W'($urandom);
        a_sgn  = 1'($urandom);
        b_sgn  = 1'($urandom);
        a_exp  = EXP_W'($urandom);
        case ($urandom_range(0, 2))
            0:       b_exp = a_exp;
            1:       b_exp = a_exp + EXP_W'($urandom_range(0, 3));
            default: b_exp = EXP_W'($urandom);
        endcase
        a_man = rand_man();
        b_man = rand_man();
    endtask

    task automatic drive_add(input int i);
        in_op  = (i % 3 == 2) ? 2'b01 : 2'b00;
        in_tag = TAG_W'(i);
        a_sgn  = 1'b0;
        a_exp  = EXP_W'(28 + i);
        a_man  = MAN_W'(32'h280000 + i * 32'h1234);
        b_sgn  = 1'(i & 1);
        b_exp  = 6'd31;
        b_man  = 22'h300000;
    endtask

    int   i, c, stall_cnt, acc_cnt, seen;
    logic acc, held;
    res_t snap, cur;

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", 64'({y_sgn, y_exp, y_man, y_tag, y_ovf, y_unf}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        run_one("add_half",   2'b00, 4'd1, 0, 6'd31, 22'h200000, 0, 6'd31, 22'h200000, 0, 6'd32, 22'h200000, 0, 0);
        run_one("mul_half",   2'b10, 4'd2, 0, 6'd31, 22'h200000, 0, 6'd31, 22'h200000, 0, 6'd30, 22'h200000, 0, 0);
        run_one("mul_neg",    2'b10, 4'd3, 0, 6'd31, 22'h200000, 1, 6'd31, 22'h200000, 1, 6'd30, 22'h200000, 0, 0);
        run_one("sub_zero",   2'b01, 4'd4, 0, 6'd31, 22'h200000, 0, 6'd31, 22'h200000, 0, 6'd0,  22'h000000, 0, 0);
        run_one("add_bigexp_zero", 2'b00, 4'd5, 0, 6'd40, 22'h000000, 0, 6'd31, 22'h200000, 0, 6'd31, 22'h200000, 0, 0);
        run_one("add_ovf",    2'b00, 4'd6, 0, 6'd63, 22'h200000, 0, 6'd63, 22'h200000, 0, 6'd63, 22'h3FFFFF, 1, 0);
        run_one("mul_unf",    2'b10, 4'd7, 0, 6'd1,  22'h200000, 0, 6'd1,  22'h200000, 0, 6'd0,  22'h000000, 0, 1);
        run_one("pass_unnorm", 2'b11, 4'd8, 0, 6'd30, 22'h000001, 1, 6'd5,  22'h000123, 0, 6'd9,  22'h200000, 0, 0);
        run_one("add_gap22",  2'b00, 4'd9, 1, 6'd40, 22'h2ABCDE, 0, 6'd18, 22'h3FFFFF, 1, 6'd40, 22'h2ABCDE, 0, 0);
        run_one("sub_align",  2'b01, 4'd10, 0, 6'd31, 22'h300000, 0, 6'd30, 22'h200000, 0, 6'd31, 22'h200000, 0, 0);
        run_one("add_neg_big", 2'b00, 4'd11, 0, 6'd31, 22'h200000, 1, 6'd32, 22'h300000, 1, 6'd32, 22'h200000, 0, 0);

        acc_cnt = 0;
        for (int k = 0; k < 1500 && acc_cnt < 400; k++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) acc_cnt = acc_cnt + 1;
            if (acc || !in_valid) begin
                rand_op();
                in_valid = ($urandom_range(0, 4) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
        #1;
        check("random_drain", 64'(sb.size()), 64'd0);

        i = 0; c = 0; stall_cnt = 0; held = 1'b0;
        drive_add(0);
        in_valid = 1'b1;
        while ((i < 8 || sb.size() > 0) && c < 60) begin
            @(negedge clk);
            if (out_valid && !out_ready) begin
                stall_cnt = stall_cnt + 1;
                check("stall_in_ready", 64'(in_ready), 64'd0);
                cur = {y_sgn, y_exp, y_man, y_ovf, y_unf, y_tag};
                if (held) check("stall_hold", 64'(cur), 64'(snap));
                snap = cur;
                held = 1'b1;
            end else begin
                held = 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            c = c + 1;
            if (acc) begin
                i = i + 1;
                if (i < 8) drive_add(i);
                else in_valid = 1'b0;
            end
            out_ready = !(c >= 5 && c <= 7);
        end
        check("stall_cycles", 64'(stall_cnt), 64'd3);
        check("stall_all_accepted", 64'(i), 64'd8);
        check("stall_drained", 64'(sb.size()), 64'd0);

        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_op();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("pre_reset_busy", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("reset_mid_out_valid", 64'(out_valid), 64'd0);
        check("reset_mid_outputs", 64'({y_sgn, y_exp, y_man, y_tag, y_ovf, y_unf}), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = seen + 1;
        end
        check("no_stale_after_reset", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fpalu_pipe.md
Name: fpalu_pipe

Overview:
Parametrised, fully pipelined unified floating-point add/multiply unit for the FIR datapath. Operands and results use the internal right-aligned mantissa format: value = (man / 2^MAN_W) * 2^(exp - BIAS). Unlike the fixed-width FPALU, every result is normalised so that man[MAN_W-1]=1, or the value is exact zero.
- Adds a valid/ready stall handshake, a pass-through tag, a per-op opcode and overflow/underflow flags.
- Sits between the coefficient/sample fetch and the accumulator register file.

Parameters:
EXP_W, 6, exponent width; BIAS = 2^(EXP_W-1)-1
MAN_W, 22, mantissa width (fraction bits, no hidden bit)
TAG_W, 4, width of user tag carried alongside each op

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand set valid
in_ready  out  1  unit can accept operands this cycle
in_op  in  2  00 ADD, 01 SUB (a-b), 10 MUL, 11 PASS (y=a)
in_tag  in  TAG_W  user tag, returned unchanged
a_sgn, b_sgn  in  1  operand signs
a_exp, b_exp  in  EXP_W  operand exponents
a_man, b_man  in  MAN_W  operand mantissas (need not be normalised)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y_sgn  out  1  result sign
y_exp  out  EXP_W  result exponent
y_man  out  MAN_W  result mantissa, normalised or zero
y_tag  out  TAG_W  tag of this result
y_ovf  out  1  exponent overflow; result saturated
y_unf  out  1  exponent underflow; result flushed to zero

Behaviour:
- Reset: all stage valid bits and all outputs clear to 0 (out_valid=0, y_*=0); in_ready=1 once reset is released. Reset mid-operation discards every in-flight op.
- Transfer occurs on valid&&ready at either end.
- Pipeline: S1 exponent compare, swap and align; S2 add/sub or MAN_W x MAN_W multiply; S3 leading-zero count; S4 normalise shift, exponent adjust, saturate. S4 register drives the outputs.
- Latency: exactly 4 cycles from input transfer to out_valid when unstalled. Throughput is 1 op/cycle.
- Stall: global enable = !(out_valid && !out_ready). in_ready = the same enable; all stages freeze while it is low. Output data is held stable while out_valid=1 and out_ready=0. Ops are never dropped, duplicated or reordered. Bubbles do not advance as data.
- ADD/SUB: SUB inverts b_sgn. Let L be the operand with the larger exponent (tie: a), R the other.
  - R.man is shifted right by |ea-eb| with truncation; a shift ≥ MAN_W gives 0.
  - Same signs: magnitude sum at MAN_W+1 bits. A carry shifts right 1 (truncating) and adds 1 to the exponent.
  - Different signs: |L-R| using a magnitude compare after alignment; sign is that of the larger magnitude.
- Zero operand: a mantissa of 0 is exact zero whatever its exponent. If one operand is zero, the result is the other operand normalised. This fixes the large-exponent-zero case.
- MUL: y_sgn = a_sgn^b_sgn. The 2*MAN_W product keeps its upper MAN_W bits (truncate). exp = ea+eb-BIAS, computed at EXP_W+2 signed bits before normalisation. Either mantissa zero gives exact zero.
- PASS: y = a, normalised.
- Normalise: left shift by lzc, exponent -= lzc, zero filled.
- Exact zero: y_man=0, y_exp=0, y_sgn=0, no flags.
- Overflow: adjusted exponent > 2^EXP_W-1 gives y_exp=all-ones, y_man=all-ones, sign kept, y_ovf=1.
- Underflow: adjusted exponent < 0 flushes to zero with y_unf=1 (sign 0).
- Flags are per result and are valid only with out_valid.

Test Plan:
Use defaults (BIAS=31); 0.5 = man 0x200000.
- ADD 0.5@31 + 0.5@31 → y_man=0x200000, y_exp=32, sgn 0, out_valid exactly 4 cycles after in transfer.
- MUL 0.5@31 * 0.5@31 → y_man=0x200000, y_exp=30, sgn 0; MUL with b_sgn=1 → y_sgn=1.
- SUB 0.5@31 - 0.5@31 → y_man=0, y_exp=0, y_sgn=0, no flags; ADD a=man 0 @exp 40 + b=0x200000@31 → y=0x200000@31.
- ADD 0x200000@63 + 0x200000@63 → y_exp=63, y_man=0x3FFFFF, y_ovf=1. MUL 0x200000@1 * 0x200000@1 → y=0, y_unf=1.
- Unnormalised PASS a=0x000001@30 → y_man=0x200000, y_exp=9. ADD with exponent gap 22 → y equals the larger operand exactly.
- Stream 8 ADDs with distinct tags back-to-back, out_ready low for cycles 5-7 → in_ready low during the stall, outputs held stable, all 8 tags emerge in order with correct sums. Assert rst_n mid-stream → out_valid=0 immediately, and no stale op emerges after release.
